// File: rtl/srld_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srld_pkg
//  Description : Shared definitions for the srl_delay_line block: parameter
//                range limits and the constant functions used to derive the
//                tap address width and to validate DEPTH at elaboration.
//  Ports       : none (package)
//  Options     : none
//  Revision    : 1.0  initial release
// ============================================================================
package srld_pkg;

    // Legal parameter ranges for the delay line.
    localparam int W_MAX     = 32;
    localparam int DEPTH_MAX = 1024;

    // Ceiling log2 of n, with clog2(1) = 0. Used to size tap addresses.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage : srld_pkg
`default_nettype wire

// File: rtl/srl_delay_line_if.sv
`default_nettype none
// ============================================================================
//  Module      : srl_delay_line_if
//  Description : Sample/tap bundle between a producer and srl_delay_line.
//                Carries the shift enable, input sample, tap select and the
//                registered tap data with its validity flag.
//  Signals     : ce    shift enable
//                d     input sample, W bits
//                a     tap select, AW bits (0 = newest)
//                flush history discard (only with SRLD_FLUSH_EN)
//                y     registered tap data, W bits
//                vld   y holds a sample written since reset/flush
//  Modports    : master (sample producer), slave (delay line)
//  Options     : SRLD_FLUSH_EN adds the flush signal
//  Revision    : 1.0  initial release
// ============================================================================
interface srl_delay_line_if
    import srld_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 64
);

    localparam int AW = clog2(DEPTH);

    logic          ce;
    logic [W-1:0]  d;
    logic [AW-1:0] a;
`ifdef SRLD_FLUSH_EN
    logic          flush;
`endif
    logic [W-1:0]  y;
    logic          vld;

`ifdef SRLD_FLUSH_EN
    modport master (output ce, output d, output a, output flush,
                    input  y,  input  vld);
    modport slave  (input  ce, input  d, input  a, input  flush,
                    output y,  output vld);
`else
    modport master (output ce, output d, output a,
                    input  y,  input  vld);
    modport slave  (input  ce, input  d, input  a,
                    output y,  output vld);
`endif

endinterface : srl_delay_line_if
`default_nettype wire

// File: rtl/srl_column.sv
`default_nettype none
// ============================================================================
//  Module      : srl_column
//  Description : Single-bit, DEPTH-stage addressable shift register. Storage
//                has no reset and the read port is a plain mux so synthesis
//                can map the whole column onto SRL primitives.
//  Ports       : clk  rising-edge clock
//                ce   shift enable; d enters stage 0
//                d    serial input bit
//                a    tap select (0 = most recently written bit)
//                q    combinational tap output, stage[a]
//  Options     : none
//  Revision    : 1.0  initial release
// ============================================================================
module srl_column
    import srld_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          ce,
    input  wire logic          d,
    input  wire logic [AW-1:0] a,
    output logic               q
);

    // Bit 0 is the newest stage, bit DEPTH-1 the oldest.
    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (ce) begin
            r_sr <= {r_sr[DEPTH-2:0], d};
        end
    end

    // DEPTH is a power of two, so every value of a selects a real stage.
    assign q = r_sr[a];

endmodule : srl_column
`default_nettype wire

// File: rtl/srl_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : srl_delay_line
//  Description : Parametrised addressable shift-register delay line, W bits
//                wide and DEPTH stages deep. The tap selected by a is
//                registered onto y every clock; vld flags that the selected
//                stage holds a sample written since the last reset (or flush),
//                based on a saturating fill counter.
//  Parameters  : W      data width, 1..W_MAX
//                DEPTH  stage count, power of two, 2..DEPTH_MAX
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset (y, vld, fill only)
//                bus    srl_delay_line_if slave: ce, d, a, [flush], y, vld
//  Options     : SRLD_FLUSH_EN  adds a flush input that empties the fill
//                               counter without touching stored samples
//  Revision    : 1.0  initial release
// ============================================================================
module srl_delay_line
    import srld_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input wire logic         clk,
    input wire logic         rst_n,
    srl_delay_line_if.slave  bus
);

    localparam int AW = clog2(DEPTH);

    // Fill counter is one bit wider than the address so it can hold DEPTH.
    localparam logic [AW:0] c_fill_max = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_fill_one = (AW+1)'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((W < 1) || (W > W_MAX)) begin : g_chk_w
        $error("srl_delay_line: W out of range");
    end

    if ((DEPTH < 2) || (DEPTH > DEPTH_MAX) || !is_pow2(DEPTH)) begin : g_chk_depth
        $error("srl_delay_line: DEPTH must be a power of two in range");
    end

    // ------------------------------------------------------------------
    // Storage: one addressable SRL column per data bit
    // ------------------------------------------------------------------
    logic [W-1:0] w_tap;

    for (genvar gi = 0; gi < W; gi++) begin : g_col
        srl_column #(
            .DEPTH (DEPTH)
        ) u_col (
            .clk (clk),
            .ce  (bus.ce),
            .d   (bus.d[gi]),
            .a   (bus.a),
            .q   (w_tap[gi])
        );
    end

    // ------------------------------------------------------------------
    // Fill counter next state
    // ------------------------------------------------------------------
    logic [AW:0] r_fill;
    logic [AW:0] w_fill_nxt;

    always_comb begin
        w_fill_nxt = r_fill;
        // Saturate at DEPTH: once full, every tap stays valid.
        if (bus.ce && (r_fill != c_fill_max)) begin
            w_fill_nxt = r_fill + c_fill_one;
        end
`ifdef SRLD_FLUSH_EN
        // A flush that coincides with a write keeps that one new sample.
        if (bus.flush) begin
            w_fill_nxt = bus.ce ? c_fill_one : '0;
        end
`endif
    end

    // Selected stage holds real data when it is younger than the fill
    // level; uses the pre-edge fill so it lines up with the tap read.
    logic w_vld_nxt;
    assign w_vld_nxt = (r_fill > {1'b0, bus.a});

    // ------------------------------------------------------------------
    // Output register and fill state
    // ------------------------------------------------------------------
    logic [W-1:0] r_y;
    logic         r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_vld  <= 1'b0;
            r_fill <= '0;
        end else begin
            // Tap register updates every edge so address changes are seen
            // even while the array is held.
            r_y    <= w_tap;
            r_vld  <= w_vld_nxt;
            r_fill <= w_fill_nxt;
        end
    end

    assign bus.y   = r_y;
    assign bus.vld = r_vld;

endmodule : srl_delay_line
`default_nettype wire

// File: tb/tb_srl_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srl_delay_line
//  Description : Directed self-checking bench for srl_delay_line, W=8,
//                DEPTH=64. Inputs change 1 time unit after each rising edge
//                and outputs are checked at the same point.
//  Options     : SRLD_FLUSH_EN enables the flush steps
//  Revision    : 1.0  initial release
// ============================================================================
module tb_srl_delay_line;

    localparam int W     = 8;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    srl_delay_line_if #(.W(W), .DEPTH(DEPTH)) bus ();

    srl_delay_line #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic [7:0] d, input logic [5:0] a);
        bus.ce = ce;
        bus.d  = d;
        bus.a  = a;
    endtask

    // Asynchronous reset pulse placed between clock edges; checks that the
    // outputs clear without waiting for a clock.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_y0"},   32'(bus.y),   32'h0);
        check({tag, "_vld0"}, 32'(bus.vld), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 6'd0);
`ifdef SRLD_FLUSH_EN
        bus.flush = 1'b0;
`endif
        // ---------------- power-on reset ----------------
        #2;
        reset_pulse("por");
        rst_n = 1'b0;
        tick();
        check("por_hold_y",   32'(bus.y),   32'h0);
        check("por_hold_vld", 32'(bus.vld), 32'h0);
        rst_n = 1'b1;

        // ---------------- stream at a=0 ----------------
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 8'(k), 6'd0);
            tick();
            if (k == 1) begin
                check("a0_vld_first", 32'(bus.vld), 32'h0);
            end else begin
                check("a0_vld", 32'(bus.vld), 32'h1);
                check("a0_y",   32'(bus.y),   32'(k - 1));
            end
        end

        // ---------------- deep tap a=63, 200 writes ----------------
        reset_pulse("rst_deep");
        for (int k = 1; k <= 200; k++) begin
            drive(1'b1, 8'(k), 6'd63);
            tick();
            if (k <= 64) begin
                check("a63_vld_lo", 32'(bus.vld), 32'h0);
            end else begin
                check("a63_vld_hi", 32'(bus.vld), 32'h1);
                check("a63_y",      32'(bus.y),   32'(k - 64));
            end
        end

        // ---------------- saturation: sweep every tap, array held ------
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'hFF, 6'(i));
            tick();
            check("sat_vld", 32'(bus.vld), 32'h1);
            check("sat_y",   32'(bus.y),   32'(200 - i));
        end

        // ---------------- ce gating at a=1 ----------------
        reset_pulse("rst_gate");
        for (int s = 1; s <= 10; s++) begin
            if (s % 2 == 1) drive(1'b1, 8'(10 + (s + 1) / 2), 6'd1);
            else            drive(1'b0, 8'hEE, 6'd1);
            tick();
            if (s < 4) begin
                check("gate_vld_lo", 32'(bus.vld), 32'h0);
            end else begin
                check("gate_vld_hi", 32'(bus.vld), 32'h1);
                check("gate_y",      32'(bus.y),   32'(9 + s / 2));
            end
        end

        // ---------------- async reset mid-stream, then a=2 ----------------
        drive(1'b1, 8'h77, 6'd2);
        reset_pulse("rst_mid");
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 8'(20 + k), 6'd2);
            tick();
            if (k < 4) begin
                check("mid_vld_lo", 32'(bus.vld), 32'h0);
            end else begin
                check("mid_vld_hi", 32'(bus.vld), 32'h1);
                check("mid_y",      32'(bus.y),   32'(20 + k - 3));
            end
        end

`ifdef SRLD_FLUSH_EN
        // ---------------- flush ----------------
        reset_pulse("rst_flush");
        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, 8'(k), 6'd0);
            tick();
        end
        check("pre_flush_y", 32'(bus.y), 32'd99);
        bus.flush = 1'b1;
        drive(1'b0, 8'h00, 6'd0);
        tick();
        bus.flush = 1'b0;
        tick();
        check("flush_ce0_vld", 32'(bus.vld), 32'h0);
        bus.flush = 1'b1;
        drive(1'b1, 8'h5A, 6'd0);
        tick();
        check("flush_ce1_vld_edge", 32'(bus.vld), 32'h0);
        bus.flush = 1'b0;
        drive(1'b0, 8'h00, 6'd0);
        tick();
        check("flush_ce1_vld", 32'(bus.vld), 32'h1);
        check("flush_ce1_y",   32'(bus.y),   32'h5A);
        drive(1'b0, 8'h00, 6'd1);
        tick();
        check("flush_ce1_a1_vld", 32'(bus.vld), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_srl_delay_line
`default_nettype wire
